vblank_update_arbiter: RTL

Round-robin arbiter that shares one object-position update port among `N_REQ` requesters, such as mouse, keyboard and animation engines. Grants are issued only inside the vertical blanking interval reported by `vga_timing`, so drawn rectangles never change mid-frame (no tearing). It sits between the requesters and the draw pipeline's position registers and is clocked by the pixel clock.

---
 rtl/vga_pkg.sv | 17 +
 rtl/rr_arb_pick.sv | 37 +++
 rtl/vblank_update_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared types and default sizing for the VGA draw pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Screen coordinate, wide enough for any supported resolution
    typedef logic [10:0] pos_t;

    // Default sizing of the blanking-window update arbiter
    localparam int ARB_N_REQ      = 4;
    localparam int ARB_MAX_GRANTS = 4;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/rr_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pick
// Brief    : Combinational round-robin picker. Selects the first eligible
//            requester at or after ptr, wrapping around N_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_pick
    import vga_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    logic w_found;

    // Scan from ptr upward (modulo N_REQ) and keep the first hit
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && elig[(int'(ptr) + k) % N_REQ]) begin
                w_found                          = 1'b1;
                pick[(int'(ptr) + k) % N_REQ]    = 1'b1;
                pick_idx                         = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule : rr_arb_pick
`default_nettype wire

// File: rtl/vblank_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vblank_update_arbiter
// Brief    : Round-robin arbiter sharing one object-position update port
//            among N_REQ requesters; grants only inside vertical blanking so
//            drawn objects never move mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module vblank_update_arbiter
    import vga_pkg::*;
#(
    parameter int   N_REQ      = ARB_N_REQ,
    parameter int   MAX_GRANTS = ARB_MAX_GRANTS,
    parameter pos_t X_RST      = '0,
    parameter pos_t Y_RST      = '0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  pos_t [N_REQ-1:0] req_xpos,
    input  pos_t [N_REQ-1:0] req_ypos,
    output logic [N_REQ-1:0] gnt,
    output pos_t             xpos_out,
    output pos_t             ypos_out,
    output logic             upd_valid,
    output logic             frame_tick
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(MAX_GRANTS + 1);

    typedef enum logic [1:0] {
        WAIT_VBLANK = 2'd0,
        ARBITRATE   = 2'd1,
        DONE        = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_vblnk_q;
    logic               r_armed;
    logic [N_REQ-1:0]   r_served;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_pick;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_rise;

    // Requesters already served this window are masked out. A rise only
    // counts once vblnk has been seen low after reset, so a reset released
    // inside blanking never reopens that same window.
    assign w_elig = req & ~r_served;
    assign w_rise = vblnk & ~r_vblnk_q & r_armed;

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .elig     (w_elig),
        .ptr      (r_ptr),
        .pick     (w_pick),
        .pick_idx (w_pick_idx)
    );

    // Blanking edge history and post-reset arming
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vblnk_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_vblnk_q <= vblnk;
            r_armed   <= r_armed | ~vblnk;
        end
    end

    // Window FSM with served mask, grant budget, fairness pointer and outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state    <= WAIT_VBLANK;
            r_served   <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            gnt        <= '0;
            upd_valid  <= 1'b0;
            frame_tick <= 1'b0;
            xpos_out   <= X_RST;
            ypos_out   <= Y_RST;
        end else begin
            gnt        <= '0;
            upd_valid  <= 1'b0;
            frame_tick <= 1'b0;
            case (r_state)
                WAIT_VBLANK: begin
                    if (w_rise) begin
                        r_state    <= ARBITRATE;
                        frame_tick <= 1'b1;
                        r_served   <= '0;
                        r_cnt      <= '0;
                    end
                end
                ARBITRATE: begin
                    if (!vblnk) begin
                        r_state <= WAIT_VBLANK;
                    end else if (|w_elig) begin
                        gnt       <= w_pick;
                        upd_valid <= 1'b1;
                        xpos_out  <= req_xpos[w_pick_idx];
                        ypos_out  <= req_ypos[w_pick_idx];
                        r_served  <= r_served | w_pick;
                        r_ptr     <= (w_pick_idx == c_IDX_W'(N_REQ - 1)) ?
                                     '0 : w_pick_idx + c_IDX_W'(1);
                        r_cnt     <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(MAX_GRANTS - 1)) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!vblnk) begin
                        r_state <= WAIT_VBLANK;
                    end
                end
                default: r_state <= WAIT_VBLANK;
            endcase
        end
    end

endmodule : vblank_update_arbiter
`default_nettype wire
